clkfreq_meter: RTL and testbench
================================

# clkfreq_meter

Gated frequency counter that measures an asynchronous clock-like input, typically a tap of the divided-clock bus or an external reference, against the 200 MHz system clock clk200m. It counts synchronized rising edges of meas_in over a fixed window of GATE_CYCLES clk200m cycles and presents the result with a one-cycle done strobe. It is the checking counterpart of the clock divider: the divider produces the slow clocks, and this block reads them back for self-test and debug readout.

## Interface
- GATE_CYCLES, 200000: window length in clk200m cycles (default 1 ms, so count × 1000 = Hz); legal range ≥ 4.
- CNT_W, 32: width of the edge counter and of the result.
- clk200m  in  1  system clock, 200 MHz.
- rst  in  1  reset, asynchronous, active-high.
- meas_in  in  1  signal under measurement, asynchronous to clk200m.
- start  in  1  one-shot measurement request, sampled on the rising edge.
- cont  in  1  continuous mode: the block re-arms automatically after each done.
- busy  out  1  high while a measurement window is open.
- done  out  1  one-cycle pulse when count and overflow are updated.
- count  out  CNT_W  edges counted in the last completed window.
- overflow  out  1  the last window's edge count saturated.

## Operation
- **Input conditioning.** meas_in passes through a 2-flop synchronizer, then a third register. A rising edge is sync2 && !sync3.
- **Guaranteed input rate.** Frequencies up to clk200m/4 (50 MHz) are measured exactly, within ±1 edge from phase. Higher frequencies give an undefined result.
- **States:**
  - IDLE → GATE when start=1 or cont=1.
  - GATE → DONE when the gate timer reaches GATE_CYCLES−1.
  - DONE → GATE if cont=1; DONE → IDLE otherwise.
- **GATE state.**
  - On entry, the gate timer and edge counter clear to 0.
  - Each cycle, the timer increments by 1.
  - The edge counter increments by 1 on each detected rising edge.
  - The edge counter saturates at 2^CNT_W−1 and sets an internal sat flag.
- **DONE state.**
  - count loads the edge counter, including any edge detected in the final GATE cycle.
  - overflow loads sat.
  - done=1 for exactly this one cycle.
- **Held results.** count and overflow hold their values until the next DONE.
- **start while busy** (GATE or DONE) is ignored, with no restart and no queuing.
- **Dropping cont** during GATE: the current window completes, then the block returns to IDLE.
- **rst mid-window.** rst asserted at any time returns the block to IDLE immediately and discards the window. No done is produced.
- **Reset values:** busy=0, done=0, count=0, overflow=0. Synchronizer flops, timer, edge counter and sat are all 0.

## Timing
- start=1 sampled at edge N gives GATE and busy=1 from edge N+1.
- The window covers exactly GATE_CYCLES cycles, N+1 .. N+GATE_CYCLES.
- done=1 in cycle N+GATE_CYCLES+1. busy is low in that cycle.
- In cont mode, the next window starts at N+GATE_CYCLES+2. The period is GATE_CYCLES+1 cycles, with a one-cycle dead time.
- Edge-to-count latency is 3 cycles (synchronizer plus edge register). Edges are attributed to the window in delayed time; this is fixed and accepted.
- Timer width is clog2(GATE_CYCLES). All arithmetic is unsigned, and the result never wraps.

## Structure
- **Package clkfreq_pkg:**
  - state enum {IDLE, GATE, DONE};
  - default GATE_CYCLES constant (200000);
  - SYS_CLK_HZ = 200_000_000.
- **Sub-module sync_rise_det:** 2-flop synchronizer, edge register, and rise-pulse output. It is reused by other asynchronous-input blocks in the design.
- **Top:** FSM, gate timer, saturating edge counter, result registers.

## Test plan
- **Reset.** rst pulsed mid-GATE → busy=0, done never pulses, count=0 and overflow=0 after reset; a following start measures normally.
- **Exact rate.** GATE_CYCLES=1000, meas_in = clk200m/16 (12.5 MHz), start pulse → done exactly 1001 cycles after start; count ∈ {62, 63}; overflow=0.
- **Idle input.** meas_in held low, start → count=0. meas_in held high → count=0 (no edges).
- **Fast input.** GATE_CYCLES=1000, meas_in at clk200m/4, start → count ∈ {249, 250}.
- **Start while busy.** start re-asserted during GATE → ignored; exactly one done at 1001 cycles.
- **Continuous mode and saturation.**
  - cont=1 with GATE_CYCLES=100 → done pulses every 101 cycles.
  - CNT_W=4 with meas_in at clk200m/4 → count=15, overflow=1.
  - cont cleared mid-window → one more done, then IDLE.

Source files
------------

// File: rtl/clkfreq_pkg.sv
// Shared types and constants for the gated clock frequency meter.
package clkfreq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned GATE_CYCLES_DEF = 200000;
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned SYS_CLK_HZ      = 200_000_000;

  // Gate timer width; never below one bit so tiny windows still elaborate.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer plus edge register producing a single-cycle rise pulse
// for an input asynchronous to i_clk.
module sync_rise_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_rise_c = r_sync2 & ~r_sync3;

endmodule

// File: rtl/clkfreq_meter.sv
// Gated frequency counter: counts synchronized rising edges of meas_in over a
// window of GATE_CYCLES clk200m cycles and reports the result with a done pulse.
module clkfreq_meter
  import clkfreq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk200m,
  input  logic             rst,
  input  logic             meas_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned TMR_W = timer_width(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic               w_rise;
  logic               w_at_max;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_sat_nxt;

  sync_rise_det u_sync (
    .i_clk    (clk200m),
    .i_rst    (rst),
    .i_async  (meas_in),
    .o_rise_c (w_rise)
  );

  // Saturating edge count including the edge seen in the current cycle.
  always_comb begin
    w_at_max  = &r_cnt;
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (w_rise) begin
      if (w_at_max) w_sat_nxt = 1'b1;
      else          w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start || cont) begin
            r_state <= GATE;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end
        end
        GATE: begin
          r_cnt   <= w_cnt_nxt;
          r_sat   <= w_sat_nxt;
          r_timer <= r_timer + TMR_W'(1);
          if (r_timer == TMR_LAST) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_count    <= w_cnt_nxt;
            r_overflow <= w_sat_nxt;
          end
        end
        DONE: begin
          // start is ignored here; only cont re-arms without a dead IDLE cycle.
          if (cont) begin
            r_state <= GATE;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_clkfreq_meter.sv
// Randomized self-checking bench for clkfreq_meter; expected counts come from
// a history of sampled meas_in rising edges and the window arithmetic.
module tb_clkfreq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas_in = 1'b0;
  logic [1:0]  start_v = 2'b00;
  logic [1:0]  cont_v  = 2'b00;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [1:0]  ovf_v;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rise_q[$];
  logic prev_s = 1'b0;

  int   gen_mode = 0;
  int   gen_half = 8;
  int   hold     = 1;
  logic gen_lvl  = 1'b0;

  clkfreq_meter #(.GATE_CYCLES(1000), .CNT_W(32)) dut_a (
    .clk200m(clk), .rst(rst), .meas_in(meas_in), .start(start_v[0]), .cont(cont_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .count(cnt_a), .overflow(ovf_v[0])
  );

  clkfreq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk200m(clk), .rst(rst), .meas_in(meas_in), .start(start_v[1]), .cont(cont_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .count(cnt_b), .overflow(ovf_v[1])
  );

  always #5 clk = ~clk;

  // Record the cycle index of every rising edge the design can sample.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) prev_s = 1'b0;
    else begin
      if (meas_in && !prev_s) rise_q.push_back(cyc);
      prev_s = meas_in;
    end
  end

  // meas_in source: static level, fixed half-period, or random hold of 2..9 cycles.
  always @(negedge clk) begin
    if (gen_mode == 0) meas_in = gen_lvl;
    else if (hold <= 1) begin
      meas_in = ~meas_in;
      hold = (gen_mode == 1) ? gen_half : int'($urandom_range(9, 2));
    end else hold = hold - 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint count_of(input int idx);
    return (idx == 0) ? longint'(cnt_a) : longint'(cnt_b);
  endfunction

  // Edges sampled at cycle k reach the counter two cycles later, so a window
  // entered at edge n attributes samples n-1 .. n+g-2.
  function automatic void model(input int n, input int g, input int w,
                                output longint ec, output longint eo);
    longint c  = 0;
    longint mx = (longint'(1) << w) - 1;
    foreach (rise_q[i])
      if (rise_q[i] >= n - 1 && rise_q[i] <= n + g - 2) c++;
    ec = (c > mx) ? mx : c;
    eo = (c > mx) ? 1 : 0;
  endfunction

  task automatic wait_done(input int idx, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_v[idx]) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic measure(input int idx, input int g, input int w, input int restart_at,
                         output longint got);
    int n, t, extra;
    longint ec, eo;
    @(negedge clk); start_v[idx] = 1'b1; n = cyc + 1;
    @(negedge clk); start_v[idx] = 1'b0;
    check_eq("busy_after_start", busy_v[idx], 1);
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      start_v[idx] = 1'b1;
      @(negedge clk); start_v[idx] = 1'b0;
    end
    wait_done(idx, g + 20, t);
    check_eq("done_cycle", t, n + g);
    check_eq("busy_in_done", busy_v[idx], 0);
    model(n, g, w, ec, eo);
    got = count_of(idx);
    check_eq("count", got, ec);
    check_eq("overflow", ovf_v[idx], eo);
    extra = 0;
    repeat (150) begin
      @(negedge clk);
      if (done_v[idx]) extra++;
    end
    check_eq("no_extra_done", extra, 0);
    check_eq("idle_after", busy_v[idx], 0);
  endtask

  initial begin
    longint got, ec, eo;
    int n, t, extra;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_busy", busy_v[i], 0);
      check_eq("rst_done", done_v[i], 0);
      check_eq("rst_count", count_of(i), 0);
      check_eq("rst_ovf", ovf_v[i], 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 12.5 MHz input.
    gen_mode = 1; gen_half = 8;
    repeat (5) @(negedge clk);
    measure(0, 1000, 32, 0, got);
    check_eq("rate16_range", (got >= 62 && got <= 63), 1);

    // Static inputs produce no edges.
    gen_mode = 0; gen_lvl = 1'b0;
    repeat (6) @(negedge clk);
    measure(0, 1000, 32, 0, got);
    check_eq("idle_low_zero", got, 0);
    gen_lvl = 1'b1;
    repeat (6) @(negedge clk);
    measure(0, 1000, 32, 0, got);
    check_eq("idle_high_zero", got, 0);

    // clk200m/4 input.
    gen_mode = 1; gen_half = 2;
    repeat (5) @(negedge clk);
    measure(0, 1000, 32, 0, got);
    check_eq("rate4_range", (got >= 249 && got <= 250), 1);

    // start re-asserted mid-window is ignored.
    gen_half = 8;
    measure(0, 1000, 32, 500, got);

    // Reset mid-window discards the measurement.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", busy_v[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (1100) begin
      @(negedge clk);
      if (done_v[0]) extra++;
    end
    check_eq("rst_mid_no_done", extra, 0);
    check_eq("rst_mid_count", count_of(0), 0);
    check_eq("rst_mid_ovf", ovf_v[0], 0);
    gen_mode = 2;
    measure(0, 1000, 32, 0, got);

    // Saturation of the 4-bit counter.
    gen_mode = 1; gen_half = 2;
    repeat (4) @(negedge clk);
    measure(1, 100, 4, 0, got);
    check_eq("sat_count", got, 15);
    check_eq("sat_ovf", ovf_v[1], 1);

    // Continuous mode: period 101, then cont dropped mid-window.
    gen_mode = 2;
    @(negedge clk); cont_v[1] = 1'b1; n = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        repeat (50) @(negedge clk);
        cont_v[1] = 1'b0;
      end
      wait_done(1, 120, t);
      check_eq("cont_done_cycle", t, n + 101 * k + 100);
      model(n + 101 * k, 100, 4, ec, eo);
      check_eq("cont_count", count_of(1), ec);
      check_eq("cont_ovf", ovf_v[1], eo);
    end
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_v[1]) extra++;
    end
    check_eq("cont_stop_no_done", extra, 0);
    check_eq("cont_stop_idle", busy_v[1], 0);

    // Randomized windows at random phase and rates.
    for (int r = 0; r < 6; r++) begin
      gen_mode = ($urandom_range(1, 0) == 0) ? 1 : 2;
      gen_half = int'($urandom_range(12, 2));
      repeat ($urandom_range(7, 1)) @(negedge clk);
      if (r < 4) measure(1, 100, 4, 0, got);
      else       measure(0, 1000, 32, 0, got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
